// File: rtl/alarm_arm_controller.sv
// Keypad arm/disarm sequencer: matches CODE_LEN one-hot digits, then runs exit/entry delay and siren FSM.
// Outputs registered, status moves on the last digit's edge; no backpressure. `ALARM_LOCKOUT_EN adds keypad lockout.
module alarm_arm_controller #(
   parameter int                    CODE_LEN  = 4,
   parameter logic [4*CODE_LEN-1:0] CODE      = 16'h8421,
   parameter int                    EXIT_DLY  = 8,
   parameter int                    ENTRY_DLY = 8,
   parameter int                    MAX_FAIL  = 3,
   parameter int                    LOCK_CYC  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] din,
   input  logic       sensor,
   output logic [2:0] status,
   output logic [3:0] chars,
   output logic       siren,
   output logic       code_ok,
   output logic       code_fail,
   output logic       locked
);

   localparam int MAX_DLY = (EXIT_DLY > ENTRY_DLY) ?
                            ((EXIT_DLY > LOCK_CYC) ? EXIT_DLY : LOCK_CYC) :
                            ((ENTRY_DLY > LOCK_CYC) ? ENTRY_DLY : LOCK_CYC);
   localparam int TW = $clog2(MAX_DLY + 1);
   localparam logic [TW-1:0] EXIT_T   = TW'(EXIT_DLY - 1);
   localparam logic [TW-1:0] ENTRY_T  = TW'(ENTRY_DLY - 1);
   localparam logic [3:0]    LAST_IDX = 4'(CODE_LEN - 1);

   if (CODE_LEN < 1 || CODE_LEN > 15 || EXIT_DLY < 1 || ENTRY_DLY < 1 ||
       MAX_FAIL < 1 || LOCK_CYC < 1) begin : g_bad_cfg
      $error("alarm_arm_controller: parameter out of legal range");
   end

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_ARMING   = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4
   } state_t;

   state_t        state;
   logic [TW-1:0] tmr;
   logic          lock_q;
   logic          match;
   logic [3:0]    exp_digit;
   logic          key_vld;
   logic          digit_ok;
   logic          last_key;
   logic          ok_now;
   logic          fail_now;

   always_comb begin
      exp_digit = '0;
      for (int i = 0; i < CODE_LEN; i++)
         if (chars == 4'(i)) exp_digit = CODE[4*i +: 4];
   end

   // match remembers whether every earlier digit of this entry was right
   assign key_vld  = (din != 4'd0) && !lock_q;
   assign digit_ok = $onehot(din) && (din == exp_digit);
   assign last_key = key_vld && (chars == LAST_IDX);
   assign ok_now   = last_key && match && digit_ok;
   assign fail_now = last_key && !(match && digit_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chars     <= '0;
         match     <= 1'b1;
         code_ok   <= 1'b0;
         code_fail <= 1'b0;
      end else begin
         code_ok   <= ok_now;
         code_fail <= fail_now;
         if (last_key) begin
            chars <= '0;
            match <= 1'b1;
         end else if (key_vld) begin
            chars <= chars + 4'd1;
            match <= match & digit_ok;
         end
      end
   end

   // a correct code always wins over timer expiry in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_DISARMED;
         tmr   <= '0;
         siren <= 1'b0;
      end else begin
         case (state)
            S_DISARMED: begin
               if (ok_now) begin
                  state <= S_ARMING;
                  tmr   <= EXIT_T;
               end
            end
            S_ARMING: begin
               if (ok_now) begin
                  state <= S_DISARMED;
                  tmr   <= '0;
               end else if (tmr == '0) begin
                  state <= S_ARMED;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_ARMED: begin
               if (ok_now) begin
                  state <= S_DISARMED;
               end else if (sensor) begin
                  state <= S_ENTRY;
                  tmr   <= ENTRY_T;
               end
            end
            S_ENTRY: begin
               if (ok_now) begin
                  state <= S_DISARMED;
                  tmr   <= '0;
               end else if (tmr == '0) begin
                  state <= S_ALARM;
                  siren <= 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_ALARM: begin
               if (ok_now) begin
                  state <= S_DISARMED;
                  siren <= 1'b0;
               end
            end
            default: begin
               state <= S_DISARMED;
               tmr   <= '0;
               siren <= 1'b0;
            end
         endcase
      end
   end

   assign status = state;

`ifdef ALARM_LOCKOUT_EN
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
   localparam logic [TW-1:0] LOCK_T    = TW'(LOCK_CYC - 1);

   logic [FW-1:0] fail_cnt;
   logic [TW-1:0] lock_tmr;

   // keypad is gated while locked, so ok_now/fail_now cannot fire then
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_cnt <= '0;
         lock_tmr <= '0;
         lock_q   <= 1'b0;
      end else if (lock_q) begin
         if (lock_tmr == '0) begin
            lock_q   <= 1'b0;
            fail_cnt <= '0;
         end else begin
            lock_tmr <= lock_tmr - 1'b1;
         end
      end else if (ok_now) begin
         fail_cnt <= '0;
      end else if (fail_now) begin
         if (fail_cnt >= FAIL_LAST) begin
            fail_cnt <= FAIL_MAX;
            lock_q   <= 1'b1;
            lock_tmr <= LOCK_T;
         end else begin
            fail_cnt <= fail_cnt + 1'b1;
         end
      end
   end

   assign locked = lock_q;
`else
   assign lock_q = 1'b0;
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Bench for alarm_arm_controller: directed vector table, corner sequences, then random traffic vs a queue-based model.
module tb_alarm_arm_controller;

   localparam int CODE_LEN  = 4;
   localparam int EXIT_DLY  = 8;
   localparam int ENTRY_DLY = 8;
   localparam int MAX_FAIL  = 3;
   localparam int LOCK_CYC  = 16;

   localparam logic [3:0] KA = 4'h1;
   localparam logic [3:0] KB = 4'h2;
   localparam logic [3:0] KC = 4'h4;
   localparam logic [3:0] KD = 4'h8;

   localparam int DIS    = 0;
   localparam int ARMING = 1;
   localparam int ARMED  = 2;
   localparam int ENTRY  = 3;
   localparam int ALARM  = 4;

`ifdef ALARM_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] din;
      logic       sensor;
      int         rep;
      logic [2:0] st;
      logic [3:0] chars;
      logic       ok;
      logic       fail;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] din = 4'h0;
   logic       sensor = 1'b0;
   logic [2:0] status;
   logic [3:0] chars;
   logic       siren;
   logic       code_ok;
   logic       code_fail;
   logic       locked;

   int checks = 0;
   int failures = 0;

   logic [3:0] code_d [CODE_LEN];
   vec_t       tbl[$];

   // reference model: digits typed so far, phase and cycles spent in the current delay phase
   logic [3:0] mq[$];
   int         m_st;
   int         m_since;
   bit         m_ok;
   bit         m_fail;
   bit         m_locked;
`ifdef ALARM_LOCKOUT_EN
   int         m_fails;
   int         m_lock_since;
`endif

   alarm_arm_controller #(
      .CODE_LEN (CODE_LEN),
      .CODE     (16'h8421),
      .EXIT_DLY (EXIT_DLY),
      .ENTRY_DLY(ENTRY_DLY),
      .MAX_FAIL (MAX_FAIL),
      .LOCK_CYC (LOCK_CYC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .sensor   (sensor),
      .status   (status),
      .chars    (chars),
      .siren    (siren),
      .code_ok  (code_ok),
      .code_fail(code_fail),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(input logic [3:0] d, input logic s, input int rep,
                              input int st, input int ch, input logic ok, input logic fl);
      vec_t r;
      r.din = d; r.sensor = s; r.rep = rep;
      r.st = 3'(st); r.chars = 4'(ch); r.ok = ok; r.fail = fl;
      return r;
   endfunction

   task automatic chk(input string name, input logic [2:0] st, input logic [3:0] ch,
                      input logic ok, input logic fl, input logic lk);
      logic [10:0] act;
      logic [10:0] exp;
      act = {status, chars, siren, code_ok, code_fail, locked};
      exp = {st, ch, (st == 3'd4), ok, fl, lk};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: got status=%0d chars=%0d siren=%b ok=%b fail=%b locked=%b, want status=%0d chars=%0d siren=%b ok=%b fail=%b locked=%b",
                  name, $time, status, chars, siren, code_ok, code_fail, locked,
                  exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_st = DIS; m_since = 0; m_ok = 0; m_fail = 0; m_locked = 0;
`ifdef ALARM_LOCKOUT_EN
      m_fails = 0; m_lock_since = 0;
`endif
   endtask

   task automatic model_update();
      bit was_locked;
      was_locked = m_locked;
      m_ok = 0;
      m_fail = 0;
      if (!was_locked && din != 4'h0) begin
         mq.push_back(din);
         if (mq.size() == CODE_LEN) begin
            m_ok = 1;
            foreach (mq[i]) if (mq[i] != code_d[i]) m_ok = 0;
            m_fail = !m_ok;
            mq.delete();
         end
      end
      if (m_ok) begin
         if (m_st == DIS) begin m_st = ARMING; m_since = 0; end
         else m_st = DIS;
      end else begin
         case (m_st)
            ARMING: begin m_since++; if (m_since == EXIT_DLY) m_st = ARMED; end
            ARMED:  if (sensor) begin m_st = ENTRY; m_since = 0; end
            ENTRY:  begin m_since++; if (m_since == ENTRY_DLY) m_st = ALARM; end
            default: ;
         endcase
      end
`ifdef ALARM_LOCKOUT_EN
      if (was_locked) begin
         m_lock_since++;
         if (m_lock_since == LOCK_CYC) begin m_locked = 0; m_fails = 0; end
      end else if (m_ok) begin
         m_fails = 0;
      end else if (m_fail) begin
         m_fails++;
         if (m_fails >= MAX_FAIL) begin m_locked = 1; m_lock_since = 0; end
      end
`endif
   endtask

   // drive now, let one posedge sample it, settle the model, then sit 1 time unit past the edge
   task automatic step(input logic [3:0] d, input logic s);
      din = d;
      sensor = s;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic pulse_reset(input string nm);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk(nm, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic enter_code(input string nm, input int st_before, input int st_after);
      for (int j = 0; j < CODE_LEN; j++) begin
         step(code_d[j], 1'b0);
         if (j < CODE_LEN - 1) chk(nm, 3'(st_before), 4'(j + 1), 1'b0, 1'b0, 1'b0);
         else                  chk(nm, 3'(st_after), 4'd0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      code_d = '{KA, KB, KC, KD};

      // arm, exit delay boundary
      tbl.push_back(v(KA, 0, 1, 0, 1, 0, 0));
      tbl.push_back(v(KB, 0, 1, 0, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 1, 0, 1, 0));
      tbl.push_back(v(0,  0, 7, 1, 0, 0, 0));
      tbl.push_back(v(0,  0, 1, 2, 0, 0, 0));
      // intrusion, entry delay, alarm, disarm from alarm
      tbl.push_back(v(0,  1, 1, 3, 0, 0, 0));
      tbl.push_back(v(0,  0, 7, 3, 0, 0, 0));
      tbl.push_back(v(0,  0, 1, 4, 0, 0, 0));
      tbl.push_back(v(KA, 0, 1, 4, 1, 0, 0));
      tbl.push_back(v(KB, 0, 1, 4, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 4, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 0, 0, 1, 0));
      tbl.push_back(v(0,  1, 2, 0, 0, 0, 0));
      // wrong code A,A,C,D
      tbl.push_back(v(KA, 0, 1, 0, 1, 0, 0));
      tbl.push_back(v(KA, 0, 1, 0, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 0, 0, 0, 1));
      tbl.push_back(v(0,  0, 1, 0, 0, 0, 0));
      // held key counts every cycle
      tbl.push_back(v(KA, 0, 1, 0, 1, 0, 0));
      tbl.push_back(v(KA, 0, 1, 0, 2, 0, 0));
      tbl.push_back(v(KA, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(KA, 0, 1, 0, 0, 0, 1));
      // disarm on the very edge the entry timer expires; sensor ignored in ENTRY
      tbl.push_back(v(KA, 0, 1, 0, 1, 0, 0));
      tbl.push_back(v(KB, 0, 1, 0, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 1, 0, 1, 0));
      tbl.push_back(v(0,  0, 7, 1, 0, 0, 0));
      tbl.push_back(v(0,  0, 1, 2, 0, 0, 0));
      tbl.push_back(v(0,  1, 1, 3, 0, 0, 0));
      tbl.push_back(v(0,  1, 4, 3, 0, 0, 0));
      tbl.push_back(v(KA, 0, 1, 3, 1, 0, 0));
      tbl.push_back(v(KB, 0, 1, 3, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 3, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 0, 0, 1, 0));
      tbl.push_back(v(0,  0, 10, 0, 0, 0, 0));
      // non-one-hot key is a wrong digit but still counts
      tbl.push_back(v(4'h3, 0, 1, 0, 1, 0, 0));
      tbl.push_back(v(KB, 0, 1, 0, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 0, 0, 0, 1));
      // arm, then disarm while still in ARMING
      tbl.push_back(v(KA, 0, 1, 0, 1, 0, 0));
      tbl.push_back(v(KB, 0, 1, 0, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 1, 0, 1, 0));
      tbl.push_back(v(KA, 0, 1, 1, 1, 0, 0));
      tbl.push_back(v(KB, 0, 1, 1, 2, 0, 0));
      tbl.push_back(v(KC, 0, 1, 1, 3, 0, 0));
      tbl.push_back(v(KD, 0, 1, 0, 0, 1, 0));

      rst_n = 1'b0;
      din = 4'h0;
      sensor = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].rep; r++) begin
            step(tbl[i].din, tbl[i].sensor);
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].chars, tbl[i].ok, tbl[i].fail, 1'b0);
         end
      end

      // repeated wrong codes: lockout when enabled, plain failures otherwise
      for (int k = 0; k < MAX_FAIL; k++) begin
         for (int j = 0; j < CODE_LEN; j++) begin
            step(KD, 1'b0);
            if (j == CODE_LEN - 1)
               chk($sformatf("wrong%0d", k), 3'd0, 4'd0, 1'b0, 1'b1, LOCK_EN && (k == MAX_FAIL - 1));
         end
      end
`ifdef ALARM_LOCKOUT_EN
      for (int j = 0; j < CODE_LEN; j++) begin
         step(code_d[j], 1'b0);
         chk("lock_ignore", 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      end
      for (int j = CODE_LEN + 1; j < LOCK_CYC; j++) step(4'h0, 1'b0);
      chk("lock_hold", 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      step(4'h0, 1'b0);
      chk("lock_release", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif
      enter_code("after_lock_arm", DIS, ARMING);
      enter_code("after_lock_disarm", ARMING, DIS);

      // async reset mid-entry while ARMING, then a clean re-arm
      enter_code("arm6", DIS, ARMING);
      step(KA, 1'b0);
      chk("part1", 3'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      step(KB, 1'b0);
      chk("part2", 3'd1, 4'd2, 1'b0, 1'b0, 1'b0);
      pulse_reset("async_reset");
      enter_code("rearm", DIS, ARMING);
      repeat (EXIT_DLY - 1) step(4'h0, 1'b0);
      chk("rearm_wait", 3'd1, 4'd0, 1'b0, 1'b0, 1'b0);
      step(4'h0, 1'b0);
      chk("rearm_armed", 3'd2, 4'd0, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 4000; n++) begin
         int         r;
         logic [3:0] d;
         logic       s;
         if ($urandom_range(0, 799) == 0) pulse_reset("rand_reset");
         r = $urandom_range(0, 99);
         if (r < 55)      d = 4'h0;
         else if (r < 85) d = code_d[mq.size()];
         else if (r < 95) d = 4'b0001 << $urandom_range(0, 3);
         else             d = 4'($urandom_range(1, 15));
         s = ($urandom_range(0, 9) == 0);
         step(d, s);
         chk("rand", m_st[2:0], 4'(mq.size()), m_ok, m_fail, m_locked);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
